// File: rtl/stream_sink_check.sv
// stream_sink_check
//   Receive-side checker for the byte source generator. It terminates an
//   8-bit valid/ready byte stream and throttles it through ready. It
//   regenerates the transmit pattern locally, which is either a constant
//   byte or a dual-LFSR PRBS. It locks onto the incoming stream and then
//   accumulates byte, bit-error and loss-of-lock statistics for BER
//   measurement.
//
// Ports
//   aclk         clock
//   reset_n      asynchronous active-low reset
//   en           sink enable; ready drops the cycle after en goes low
//   clear        synchronous pulse that zeroes all statistics counters
//   data[7:0]    received byte, sampled only on a transfer
//   valid        data qualifier
//   ready        sink can accept; a transfer is valid & ready
//   locked       high while in the LOCKED state
//   err_pulse    one-cycle pulse per errored byte accepted while locked
//   byte_cnt     bytes accepted while locked (saturating)
//   bit_err_cnt  bit errors seen while locked (saturating)
//   loss_cnt     number of LOCKED->SEARCH transitions (saturating)
module stream_sink_check #(
  parameter int          PATTERN_MODE = 1,
  parameter logic [7:0]  CONST_BYTE   = 8'hAA,
  parameter logic [15:0] SEED16       = 16'hACE1,
  parameter logic [31:0] SEED32       = 32'hDEADBEEF,
  parameter int          SYNC_LEN     = 4,
  parameter int          LOSS_THR     = 8,
  parameter int          READY_DIV    = 1
) (
  input  logic        aclk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clear,
  input  logic [7:0]  data,
  input  logic        valid,
  output logic        ready,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] byte_cnt,
  output logic [31:0] bit_err_cnt,
  output logic [15:0] loss_cnt
);

  localparam int TW = (READY_DIV > 1) ? $clog2(READY_DIV) : 1;
  localparam logic [TW-1:0] THR_LAST = TW'(READY_DIV - 1);
  localparam int CMAX = (SYNC_LEN > LOSS_THR) ? SYNC_LEN : LOSS_THR;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SYNC_C = CW'(SYNC_LEN);
  localparam logic [CW-1:0] LOSS_C = CW'(LOSS_THR);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [31:0] lfsr32_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Throttle: ready is registered and goes high one cycle after the
  // divider counter sits at zero.
  logic [TW-1:0] thr_cnt_reg;
  logic          ready_reg;

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      thr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else if (en) begin
      ready_reg   <= (thr_cnt_reg == '0);
      thr_cnt_reg <= (thr_cnt_reg == THR_LAST) ? '0 : thr_cnt_reg + TW'(1);
    end else begin
      ready_reg   <= 1'b0;
      thr_cnt_reg <= '0;
    end
  end

  state_t        state_reg, state_next;
  logic [15:0]   lfsr16_reg, lfsr16_next;
  logic [31:0]   lfsr32_reg, lfsr32_next;
  logic [CW-1:0] match_reg, match_next;
  logic [CW-1:0] miss_reg, miss_next;
  logic          err_reg, err_next;
  logic [31:0]   byte_cnt_reg, byte_cnt_next;
  logic [31:0]   bit_err_reg, bit_err_next;
  logic [15:0]   loss_reg, loss_next;

  logic          xfer;
  logic [7:0]    exp_byte;
  logic [7:0]    diff;
  logic          hit;
  logic [3:0]    nerr;
  logic [32:0]   be_sum;

  assign xfer     = valid & ready_reg;
  assign exp_byte = (PATTERN_MODE != 0) ? (lfsr16_reg[7:0] ^ lfsr32_reg[15:8]) : CONST_BYTE;
  assign diff     = data ^ exp_byte;
  assign hit      = (diff == 8'd0);
  assign nerr     = 4'($countones(diff));
  // One extra bit catches overflow so the error count can saturate.
  assign be_sum   = {1'b0, bit_err_reg} + {29'd0, nerr};

  always_comb begin
    state_next    = state_reg;
    lfsr16_next   = lfsr16_reg;
    lfsr32_next   = lfsr32_reg;
    match_next    = match_reg;
    miss_next     = miss_reg;
    err_next      = 1'b0;
    byte_cnt_next = byte_cnt_reg;
    bit_err_next  = bit_err_reg;
    loss_next     = loss_reg;

    if (xfer) begin
      case (state_reg)
        ST_SEARCH: begin
          // On a mismatch the LFSRs are already at the seed, so nothing moves.
          if (hit) begin
            lfsr16_next = lfsr16_step(lfsr16_reg);
            lfsr32_next = lfsr32_step(lfsr32_reg);
            if (SYNC_LEN <= 1) begin
              state_next = ST_LOCKED;
              match_next = '0;
              miss_next  = '0;
            end else begin
              state_next = ST_SYNC;
              match_next = CW'(1);
            end
          end
        end
        ST_SYNC: begin
          if (hit) begin
            lfsr16_next = lfsr16_step(lfsr16_reg);
            lfsr32_next = lfsr32_step(lfsr32_reg);
            if ((match_reg + CW'(1)) == SYNC_C) begin
              state_next = ST_LOCKED;
              match_next = '0;
              miss_next  = '0;
            end else begin
              match_next = match_reg + CW'(1);
            end
          end else begin
            // The offending byte is not retried against the seed.
            lfsr16_next = SEED16;
            lfsr32_next = SEED32;
            match_next  = '0;
            state_next  = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          lfsr16_next   = lfsr16_step(lfsr16_reg);
          lfsr32_next   = lfsr32_step(lfsr32_reg);
          byte_cnt_next = (&byte_cnt_reg) ? byte_cnt_reg : byte_cnt_reg + 32'd1;
          bit_err_next  = be_sum[32] ? '1 : be_sum[31:0];
          if (!hit) begin
            err_next = 1'b1;
            if ((miss_reg + CW'(1)) == LOSS_C) begin
              // The beat that trips the threshold is still counted above.
              lfsr16_next = SEED16;
              lfsr32_next = SEED32;
              miss_next   = '0;
              loss_next   = (&loss_reg) ? loss_reg : loss_reg + 16'd1;
              state_next  = ST_SEARCH;
            end else begin
              miss_next = miss_reg + CW'(1);
            end
          end else begin
            miss_next = '0;
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end

    // clear outranks a coincident locked beat; only the statistics are lost.
    if (clear) begin
      byte_cnt_next = '0;
      bit_err_next  = '0;
      loss_next     = '0;
    end
  end

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_SEARCH;
      lfsr16_reg   <= SEED16;
      lfsr32_reg   <= SEED32;
      match_reg    <= '0;
      miss_reg     <= '0;
      err_reg      <= 1'b0;
      byte_cnt_reg <= '0;
      bit_err_reg  <= '0;
      loss_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      lfsr16_reg   <= lfsr16_next;
      lfsr32_reg   <= lfsr32_next;
      match_reg    <= match_next;
      miss_reg     <= miss_next;
      err_reg      <= err_next;
      byte_cnt_reg <= byte_cnt_next;
      bit_err_reg  <= bit_err_next;
      loss_reg     <= loss_next;
    end
  end

  assign ready       = ready_reg;
  assign locked      = (state_reg == ST_LOCKED);
  assign err_pulse   = err_reg;
  assign byte_cnt    = byte_cnt_reg;
  assign bit_err_cnt = bit_err_reg;
  assign loss_cnt    = loss_reg;

endmodule

// File: tb/tb_stream_sink_check.sv
// Bench for stream_sink_check. dut0 runs in PRBS mode with READY_DIV = 1.
// dut1 runs in constant mode with READY_DIV = 4. A reference model of the
// lock/statistics rules, indexed by pattern position, is checked every cycle.
module tb_stream_sink_check;
  localparam int NPAT = 4096;
  localparam int M_SEARCH = 0;
  localparam int M_SYNC   = 1;
  localparam int M_LOCKED = 2;

  logic aclk = 1'b0;
  logic reset_n;
  logic en0, clear0, valid0;
  logic en1, clear1, valid1;
  logic [7:0] data0, data1;
  logic ready0, locked0, err_pulse0;
  logic ready1, locked1, err_pulse1;
  logic [31:0] byte_cnt0, bit_err_cnt0, byte_cnt1, bit_err_cnt1;
  logic [15:0] loss_cnt0, loss_cnt1;

  always #5 aclk = ~aclk;

  stream_sink_check #(.PATTERN_MODE(1), .READY_DIV(1)) dut0 (
    .aclk(aclk), .reset_n(reset_n), .en(en0), .clear(clear0),
    .data(data0), .valid(valid0), .ready(ready0), .locked(locked0),
    .err_pulse(err_pulse0), .byte_cnt(byte_cnt0), .bit_err_cnt(bit_err_cnt0),
    .loss_cnt(loss_cnt0));

  stream_sink_check #(.PATTERN_MODE(0), .CONST_BYTE(8'hAA), .READY_DIV(4)) dut1 (
    .aclk(aclk), .reset_n(reset_n), .en(en1), .clear(clear1),
    .data(data1), .valid(valid1), .ready(ready1), .locked(locked1),
    .err_pulse(err_pulse1), .byte_cnt(byte_cnt1), .bit_err_cnt(bit_err_cnt1),
    .loss_cnt(loss_cnt1));

  int n_chk = 0;
  int n_fail = 0;

  // The expected PRBS byte stream is precomputed from the seeds.
  logic [7:0] pat [NPAT];

  // Reference model state for each instance.
  int     m_st [2];
  int     m_pos [2];
  int     m_match [2];
  int     m_miss [2];
  int     m_run [2];
  longint m_bc [2];
  longint m_be [2];
  longint m_loss [2];
  bit     m_ready [2];
  bit     m_err [2];
  int     ep_seen [2];

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] expb(input int i, input int pos);
    return (i == 0) ? pat[pos % NPAT] : 8'hAA;
  endfunction

  task automatic model_reset(input int i);
    m_st[i] = M_SEARCH; m_pos[i] = 0; m_match[i] = 0; m_miss[i] = 0;
    m_run[i] = 0; m_bc[i] = 0; m_be[i] = 0; m_loss[i] = 0;
    m_ready[i] = 1'b0; m_err[i] = 1'b0;
  endtask

  task automatic model_edge(input int i, input logic en_v, input logic valid_v,
                            input logic [7:0] d, input logic clr);
    bit xf;
    logic [7:0] e;
    bit ok;
    int nerr;
    xf = m_ready[i] && valid_v;
    m_err[i] = 1'b0;
    if (xf) begin
      e = expb(i, m_pos[i]);
      ok = (d == e);
      nerr = $countones(d ^ e);
      $display("dut%0d xfer data=%02h exp=%02h state=%0d clear=%0b", i, d, e, m_st[i], clr);
      if (m_st[i] == M_SEARCH) begin
        if (ok) begin
          m_pos[i] = 1; m_match[i] = 1; m_st[i] = M_SYNC;
        end
      end else if (m_st[i] == M_SYNC) begin
        if (ok) begin
          m_pos[i]++; m_match[i]++;
          if (m_match[i] == 4) begin
            m_st[i] = M_LOCKED; m_miss[i] = 0;
          end
        end else begin
          m_pos[i] = 0; m_match[i] = 0; m_st[i] = M_SEARCH;
        end
      end else begin
        m_pos[i]++;
        if (m_bc[i] < 64'hFFFF_FFFF) m_bc[i]++;
        m_be[i] = m_be[i] + nerr;
        if (m_be[i] > 64'hFFFF_FFFF) m_be[i] = 64'hFFFF_FFFF;
        if (!ok) begin
          m_err[i] = 1'b1;
          m_miss[i]++;
          if (m_miss[i] == 8) begin
            m_pos[i] = 0; m_miss[i] = 0; m_st[i] = M_SEARCH;
            if (m_loss[i] < 64'hFFFF) m_loss[i]++;
          end
        end else begin
          m_miss[i] = 0;
        end
      end
    end
    if (clr) begin
      m_bc[i] = 0; m_be[i] = 0; m_loss[i] = 0;
    end
    if (en_v) begin
      m_ready[i] = ((m_run[i] % ((i == 0) ? 1 : 4)) == 0);
      m_run[i]++;
    end else begin
      m_ready[i] = 1'b0;
      m_run[i] = 0;
    end
  endtask

  task automatic check_outs(input int i, input logic r, input logic lk, input logic ep,
                            input logic [31:0] bc, input logic [31:0] be, input logic [15:0] lc);
    chk($sformatf("dut%0d.ready", i), r, m_ready[i]);
    chk($sformatf("dut%0d.locked", i), lk, (m_st[i] == M_LOCKED));
    chk($sformatf("dut%0d.err_pulse", i), ep, m_err[i]);
    chk($sformatf("dut%0d.byte_cnt", i), bc, m_bc[i]);
    chk($sformatf("dut%0d.bit_err_cnt", i), be, m_be[i]);
    chk($sformatf("dut%0d.loss_cnt", i), lc, m_loss[i]);
    if (ep) ep_seen[i]++;
  endtask

  always @(posedge aclk) begin
    if (!reset_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, en0, valid0, data0, clear0);
      model_edge(1, en1, valid1, data1, clear1);
    end
    #1;
    check_outs(0, ready0, locked0, err_pulse0, byte_cnt0, bit_err_cnt0, loss_cnt0);
    check_outs(1, ready1, locked1, err_pulse1, byte_cnt1, bit_err_cnt1, loss_cnt1);
  end

  function automatic logic rdy(input int i);
    return (i == 0) ? ready0 : ready1;
  endfunction

  task automatic set_in(input int i, input logic v, input logic [7:0] d, input logic c);
    if (i == 0) begin valid0 = v; data0 = d; clear0 = c; end
    else        begin valid1 = v; data1 = d; clear1 = c; end
  endtask

  // Offers one byte and returns #1 after the edge on which it was accepted.
  task automatic beat(input int i, input logic [7:0] d, input logic clr);
    bit got;
    got = 1'b0;
    set_in(i, 1'b1, d, clr);
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge aclk);
      if (rdy(i)) got = 1'b1;
      @(posedge aclk);
      #1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_timeout dut%0d: got no transfer expected one within 64 cycles", i);
    end
    set_in(i, 1'b0, d, 1'b0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       lk;
    int         bc;
    int         be;
    logic       ep;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] l16;
    logic [31:0] l32;
    vec_t tbl [11];
    int sp, burst, r, xf, on_cnt, off_cnt;
    logic [7:0] mask;

    tbl[0]  = '{8'hAA, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{8'hAA, 1'b0, 0, 0, 1'b0};
    tbl[2]  = '{8'hAA, 1'b0, 0, 0, 1'b0};
    tbl[3]  = '{8'hAA, 1'b1, 0, 0, 1'b0};
    tbl[4]  = '{8'hAA, 1'b1, 1, 0, 1'b0};
    tbl[5]  = '{8'hAA, 1'b1, 2, 0, 1'b0};
    tbl[6]  = '{8'hAA, 1'b1, 3, 0, 1'b0};
    tbl[7]  = '{8'hAA, 1'b1, 4, 0, 1'b0};
    tbl[8]  = '{8'hAA, 1'b1, 5, 0, 1'b0};
    tbl[9]  = '{8'hAA, 1'b1, 6, 0, 1'b0};
    tbl[10] = '{8'hAB, 1'b1, 7, 1, 1'b1};

    l16 = 16'hACE1;
    l32 = 32'hDEADBEEF;
    for (int k = 0; k < NPAT; k++) begin
      pat[k] = l16[7:0] ^ l32[15:8];
      l16 = {l16[14:0], l16[15] ^ l16[13] ^ l16[12] ^ l16[10]};
      l32 = {l32[30:0], l32[31] ^ l32[21] ^ l32[1] ^ l32[0]};
    end

    ep_seen[0] = 0; ep_seen[1] = 0;
    reset_n = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    chk("reset.ready0", ready0, 0);
    chk("reset.locked0", locked0, 0);
    chk("reset.byte_cnt0", byte_cnt0, 0);
    chk("first_prbs_byte", pat[0], 8'h5F);
    reset_n = 1'b1;
    en0 = 1'b1;
    en1 = 1'b1;

    // Acquire lock from the seed, then 100 clean bytes.
    for (int k = 0; k < 4; k++) begin
      beat(0, pat[k], 1'b0);
      chk($sformatf("lock.locked_after_%0d", k + 1), locked0, (k == 3));
    end
    for (int k = 4; k < 104; k++) beat(0, pat[k], 1'b0);
    chk("clean.byte_cnt", byte_cnt0, 100);
    chk("clean.bit_err_cnt", bit_err_cnt0, 0);
    chk("clean.err_pulses", ep_seen[0], 0);

    // Single two-bit error, then a clean byte.
    beat(0, pat[104] ^ 8'h03, 1'b0);
    chk("err03.err_pulse", err_pulse0, 1);
    chk("err03.bit_err_cnt", bit_err_cnt0, 2);
    chk("err03.locked", locked0, 1);
    beat(0, pat[105], 1'b0);
    chk("err03.pulse_one_cycle", err_pulse0, 0);

    // Seven errors stay locked only if the miss counter was cleared.
    for (int k = 106; k < 113; k++) beat(0, pat[k] ^ 8'hFF, 1'b0);
    chk("miss7.locked", locked0, 1);
    beat(0, pat[113], 1'b0);
    for (int k = 114; k < 122; k++) begin
      beat(0, pat[k] ^ 8'hFF, 1'b0);
      chk($sformatf("loss.locked_%0d", k - 113), locked0, (k < 121));
    end
    chk("loss.bit_err_cnt", bit_err_cnt0, 2 + 56 + 64);
    chk("loss.byte_cnt", byte_cnt0, 118);
    chk("loss.loss_cnt", loss_cnt0, 1);

    // Relock from the seed.
    for (int k = 0; k < 4; k++) begin
      beat(0, pat[k], 1'b0);
      chk($sformatf("relock.locked_after_%0d", k + 1), locked0, (k == 3));
    end
    chk("relock.byte_cnt", byte_cnt0, 118);

    // clear on an errored locked beat.
    beat(0, pat[4] ^ 8'h10, 1'b1);
    chk("clear.byte_cnt", byte_cnt0, 0);
    chk("clear.bit_err_cnt", bit_err_cnt0, 0);
    chk("clear.loss_cnt", loss_cnt0, 0);
    chk("clear.err_pulse", err_pulse0, 1);
    beat(0, pat[5], 1'b0);
    chk("clear.byte_cnt_after", byte_cnt0, 1);

    // Asynchronous reset mid-stream.
    @(negedge aclk);
    reset_n = 1'b0;
    #1;
    chk("areset.ready0", ready0, 0);
    chk("areset.locked0", locked0, 0);
    chk("areset.byte_cnt0", byte_cnt0, 0);
    chk("areset.bit_err_cnt0", bit_err_cnt0, 0);
    chk("areset.loss_cnt0", loss_cnt0, 0);
    chk("areset.err_pulse0", err_pulse0, 0);
    repeat (2) @(negedge aclk);
    reset_n = 1'b1;
    @(posedge aclk);
    #1;
    for (int k = 0; k < 4; k++) begin
      beat(0, pat[k], 1'b0);
      chk($sformatf("post_reset.locked_after_%0d", k + 1), locked0, (k == 3));
    end

    // Randomized stream on dut0 with errors, bursts, idles and clears.
    sp = 4;
    burst = 0;
    for (int n = 0; n < 300; n++) begin
      if (m_st[0] == M_SEARCH) sp = 0;
      mask = 8'h00;
      if (burst > 0) begin
        mask = 8'($urandom_range(1, 255));
        burst--;
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 8) mask = 8'($urandom_range(1, 255));
        else if (r == 8) burst = 9;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
      beat(0, pat[sp % NPAT] ^ mask, ($urandom_range(0, 49) == 0));
      sp++;
    end

    // Constant mode vectors on dut1.
    for (int k = 0; k < 11; k++) begin
      beat(1, tbl[k].d, 1'b0);
      chk($sformatf("const[%0d].locked", k), locked1, tbl[k].lk);
      chk($sformatf("const[%0d].byte_cnt", k), byte_cnt1, tbl[k].bc);
      chk($sformatf("const[%0d].bit_err_cnt", k), bit_err_cnt1, tbl[k].be);
      chk($sformatf("const[%0d].err_pulse", k), err_pulse1, tbl[k].ep);
    end

    // Throttle with valid held high and en dropped for 10 cycles.
    set_in(1, 1'b1, 8'hAA, 1'b0);
    xf = 0;
    on_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge aclk);
      if (ready1) begin on_cnt++; xf++; end
    end
    chk("div4.ready_on_first", on_cnt, 10);
    @(posedge aclk);
    #1;
    en1 = 1'b0;
    off_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      if (ready1) begin
        xf++;
        if (k > 0) off_cnt++;
      end
    end
    chk("div4.ready_while_disabled", off_cnt, 0);
    @(posedge aclk);
    #1;
    en1 = 1'b1;
    on_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge aclk);
      if (ready1) begin on_cnt++; xf++; end
    end
    chk("div4.ready_on_second", on_cnt, 10);
    @(posedge aclk);
    #1;
    set_in(1, 1'b0, 8'hAA, 1'b0);
    chk("div4.byte_cnt", byte_cnt1, 7 + xf);

    // Randomized constant-mode stream on dut1.
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) beat(1, 8'($urandom_range(0, 255)), ($urandom_range(0, 39) == 0));
      else if (r < 13) begin
        for (int b = 0; b < 8; b++) beat(1, 8'h55, 1'b0);
      end else beat(1, 8'hAA, ($urandom_range(0, 39) == 0));
    end

    repeat (2) @(posedge aclk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
